// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the RAM.
// slave = arbiter side, master = requesters + RAM side.
interface ram_port_arbiter_if #(
    parameter int NB_COL    = 4,
    parameter int COL_WIDTH = 8,
    parameter int ADDR_W    = 17
);
    localparam int DW = NB_COL * COL_WIDTH;

    logic              if_req_i;
    logic [31:0]       if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DW-1:0]     if_rdata_o;
    logic              if_err_o;

    logic              d_req_i;
    logic              d_we_i;
    logic [31:0]       d_addr_i;
    logic [DW-1:0]     d_wdata_i;
    logic [NB_COL-1:0] d_be_i;
    logic              d_gnt_o;
    logic              d_rvalid_o;
    logic [DW-1:0]     d_rdata_o;
    logic              d_err_o;

    logic              ram_rd_en_o;
    logic [ADDR_W-1:0] ram_rd_addr_o;
    logic [ADDR_W-1:0] ram_wr_addr_o;
    logic [DW-1:0]     ram_wr_data_o;
    logic [NB_COL-1:0] ram_wr_strb_o;
    logic [DW-1:0]     ram_rd_data_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        output ram_rd_en_o, ram_rd_addr_o,
        output ram_wr_addr_o, ram_wr_data_o, ram_wr_strb_o,
        input  ram_rd_data_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        input  ram_rd_en_o, ram_rd_addr_o,
        input  ram_wr_addr_o, ram_wr_data_o, ram_wr_strb_o,
        output ram_rd_data_i
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM between instruction fetch and data.
// Zero-wait grants, single-cycle responses tracked by a 1-deep register.
module ram_port_arbiter #(
    parameter int NB_COL    = 4,
    parameter int COL_WIDTH = 8,
    parameter int ADDR_W    = 17
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                prog_mode_i,
    ram_port_arbiter_if.slave   bus
);
    localparam int DW = NB_COL * COL_WIDTH;

    typedef struct packed {
        logic valid;
        logic owner;
        logic err;
        logic rd;
    } rsp_t;

    rsp_t          rsp_q;
    rsp_t          rsp_d;
    logic          last_gnt_q;
    logic          allow;
    logic          if_gnt;
    logic          d_gnt;
    logic          any_gnt;
    logic [31:0]   sel_addr;
    logic          sel_ok;
    logic          sel_write;
    logic [DW-1:0] rsp_data;
    logic          if_rvalid;
    logic          d_rvalid;
    logic [DW-1:0] if_hold_q;
    logic [DW-1:0] d_hold_q;

    function automatic logic addr_ok(input logic [31:0] a);
        return (a[31:ADDR_W+2] == '0) && (a[1:0] == 2'b00);
    endfunction

    // Grant selection: lone requester wins, ties go to the one not served last.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        allow  = !rst_i && !prog_mode_i;
        if (allow) begin
            unique case ({bus.if_req_i, bus.d_req_i})
                2'b10:   if_gnt = 1'b1;
                2'b01:   d_gnt  = 1'b1;
                2'b11: begin
                    if (last_gnt_q) if_gnt = 1'b1;
                    else            d_gnt  = 1'b1;
                end
                2'b00:   ;
                default: ;
            endcase
        end
        any_gnt = if_gnt | d_gnt;
    end

    // Decode the granted request into RAM strobes and the next response.
    always_comb begin
        sel_addr  = d_gnt ? bus.d_addr_i : bus.if_addr_i;
        sel_ok    = addr_ok(sel_addr);
        sel_write = d_gnt & bus.d_we_i;

        bus.ram_rd_en_o   = any_gnt & sel_ok & !sel_write;
        bus.ram_rd_addr_o = sel_addr[ADDR_W+1:2];
        bus.ram_wr_addr_o = bus.d_addr_i[ADDR_W+1:2];
        bus.ram_wr_data_o = bus.d_wdata_i;
        bus.ram_wr_strb_o = '0;
        if (sel_write && sel_ok) begin
            bus.ram_wr_strb_o = bus.d_be_i;
        end

        rsp_d       = '0;
        rsp_d.valid = any_gnt;
        rsp_d.owner = d_gnt;
        rsp_d.err   = !sel_ok;
        rsp_d.rd    = sel_ok & !sel_write;
    end

    // Response pipeline and round-robin pointer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_q      <= '0;
            last_gnt_q <= 1'b1;
        end else begin
            rsp_q <= rsp_d;
            if (any_gnt) begin
                last_gnt_q <= d_gnt;
            end
        end
    end

    // Route the response to its owner; idle ports show their last data.
    always_comb begin
        rsp_data  = rsp_q.rd ? bus.ram_rd_data_i : '0;
        if_rvalid = rsp_q.valid & !rsp_q.owner;
        d_rvalid  = rsp_q.valid &  rsp_q.owner;

        bus.if_gnt_o    = if_gnt;
        bus.d_gnt_o     = d_gnt;
        bus.if_rvalid_o = if_rvalid;
        bus.d_rvalid_o  = d_rvalid;
        bus.if_err_o    = if_rvalid & rsp_q.err;
        bus.d_err_o     = d_rvalid & rsp_q.err;
        bus.if_rdata_o  = if_rvalid ? rsp_data : if_hold_q;
        bus.d_rdata_o   = d_rvalid ? rsp_data : d_hold_q;
    end

    // Capture delivered data so it stays visible between responses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            if_hold_q <= '0;
            d_hold_q  <= '0;
        end else begin
            if (if_rvalid) if_hold_q <= rsp_data;
            if (d_rvalid)  d_hold_q  <= rsp_data;
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: model predicts grants and
// queues expected responses; a monitor pops them as they appear.
module tb_ram_port_arbiter;
    localparam int NB_COL    = 4;
    localparam int COL_WIDTH = 8;
    localparam int ADDR_W    = 17;
    localparam int DW        = NB_COL * COL_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic prog = 1'b0;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(
        .NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .ADDR_W(ADDR_W)
    ) bus ();

    ram_port_arbiter #(
        .NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .prog_mode_i(prog),
        .bus(bus)
    );

    typedef struct {
        logic          owner;
        logic          err;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          q[$];
    int            cyc = 0;
    int            n_chk = 0;
    int            n_fail = 0;
    bit            m_last = 1'b1;
    logic [DW-1:0] hold_if = '0;
    logic [DW-1:0] hold_d = '0;
    logic [DW-1:0] ram [0:63];
    logic [DW-1:0] ref_mem [0:63];

    logic              n_rst, n_pm, n_ir, n_dr, n_dw;
    logic [31:0]       n_ia, n_da;
    logic [DW-1:0]     n_wd;
    logic [NB_COL-1:0] n_be;

    function automatic logic [DW-1:0] seed(input int i);
        if (i == 4) return 32'h0000_0013;
        return 32'(i) * 32'h9E37_79B9 ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM: one cycle read latency, byte-strobed writes.
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 64; i++) ram[i] <= seed(i);
        end else begin
            for (int b = 0; b < NB_COL; b++) begin
                if (bus.ram_wr_strb_o[b])
                    ram[bus.ram_wr_addr_o[5:0]][b*COL_WIDTH +: COL_WIDTH]
                        <= bus.ram_wr_data_o[b*COL_WIDTH +: COL_WIDTH];
            end
        end
        if (bus.ram_rd_en_o) bus.ram_rd_data_i <= ram[bus.ram_rd_addr_o[5:0]];
        else                 bus.ram_rd_data_i <= $urandom;
    end

    task automatic model();
        logic allow, ig, dg, inr, wr;
        logic [31:0] a;
        exp_t e;
        allow = !rst && !prog;
        ig = allow && bus.if_req_i && (!bus.d_req_i || m_last);
        dg = allow && bus.d_req_i && (!bus.if_req_i || !m_last);
        chk("if_gnt", bus.if_gnt_o, ig);
        chk("d_gnt", bus.d_gnt_o, dg);
        if (ig || dg) begin
            m_last = dg;
            a = dg ? bus.d_addr_i : bus.if_addr_i;
            inr = (a[31:ADDR_W+2] == 0) && (a[1:0] == 2'b00);
            wr = dg && bus.d_we_i;
            chk("ram_rd_en", bus.ram_rd_en_o, inr && !wr);
            if (inr && !wr) chk("ram_rd_addr", bus.ram_rd_addr_o, a[ADDR_W+1:2]);
            chk("ram_wr_strb", bus.ram_wr_strb_o, (inr && wr) ? bus.d_be_i : 4'b0);
            if (inr && wr) begin
                chk("ram_wr_addr", bus.ram_wr_addr_o, a[ADDR_W+1:2]);
                chk("ram_wr_data", bus.ram_wr_data_o, bus.d_wdata_i);
                for (int b = 0; b < NB_COL; b++)
                    if (bus.d_be_i[b])
                        ref_mem[a[7:2]][b*8 +: 8] = bus.d_wdata_i[b*8 +: 8];
            end
            e.owner = dg;
            e.err   = !inr;
            e.data  = (inr && !wr) ? ref_mem[a[7:2]] : '0;
            e.due   = cyc + 1;
            q.push_back(e);
        end else begin
            chk("ram_rd_en_idle", bus.ram_rd_en_o, 1'b0);
            chk("ram_wr_strb_idle", bus.ram_wr_strb_o, 4'b0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        rst = n_rst;
        prog = n_pm;
        bus.if_req_i = n_ir;
        bus.if_addr_i = n_ia;
        bus.d_req_i = n_dr;
        bus.d_we_i = n_dw;
        bus.d_addr_i = n_da;
        bus.d_wdata_i = n_wd;
        bus.d_be_i = n_be;
        if (n_rst) begin
            q.delete();
            m_last = 1'b1;
            hold_if = '0;
            hold_d = '0;
        end
        @(negedge clk);
        model();
    endtask

    task automatic idle_in();
        n_ir = 0; n_dr = 0; n_dw = 0; n_pm = 0;
        n_ia = 0; n_da = 0; n_wd = 0; n_be = 0;
    endtask

    function automatic logic [31:0] rnd_addr();
        int r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        a = 32'($urandom_range(0, 63)) << 2;
        if (r == 0) a = a | 32'($urandom_range(1, 3));
        if (r == 1) a = a | (32'd1 << $urandom_range(ADDR_W + 2, 31));
        return a;
    endfunction

    // Monitor: each cycle either the due response appears or nothing does.
    always @(negedge clk) begin
        exp_t e;
        bit have;
        have = 0;
        e = '{owner: 1'b0, err: 1'b0, data: '0, due: 0};
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            have = 1;
        end
        chk("if_rvalid", bus.if_rvalid_o, have && !e.owner);
        chk("d_rvalid", bus.d_rvalid_o, have && e.owner);
        if (have && !e.owner) begin
            chk("if_rdata", bus.if_rdata_o, e.data);
            chk("if_err", bus.if_err_o, e.err);
            hold_if = e.data;
        end else begin
            chk("if_err_idle", bus.if_err_o, 1'b0);
            chk("if_rdata_hold", bus.if_rdata_o, hold_if);
        end
        if (have && e.owner) begin
            chk("d_rdata", bus.d_rdata_o, e.data);
            chk("d_err", bus.d_err_o, e.err);
            hold_d = e.data;
        end else begin
            chk("d_err_idle", bus.d_err_o, 1'b0);
            chk("d_rdata_hold", bus.d_rdata_o, hold_d);
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = seed(i);
        bus.if_req_i = 0; bus.if_addr_i = 0;
        bus.d_req_i = 0; bus.d_we_i = 0; bus.d_addr_i = 0;
        bus.d_wdata_i = 0; bus.d_be_i = 0;
        idle_in();
        n_rst = 1;
        n_ir = 1; n_dr = 1; n_ia = 32'h10; n_da = 32'h20;
        repeat (2) step();
        chk("rst_if_rdata", bus.if_rdata_o, 0);
        chk("rst_d_rdata", bus.d_rdata_o, 0);
        chk("rst_rd_en", bus.ram_rd_en_o, 0);
        n_rst = 0;
        idle_in();
        step();

        n_ir = 1; n_ia = 32'h0000_0010;
        step();
        idle_in();
        step();

        n_rst = 1; step(); n_rst = 0;
        n_ir = 1; n_ia = 32'h10; n_dr = 1; n_da = 32'h14;
        repeat (4) step();
        idle_in();
        step();

        n_dr = 1; n_dw = 1; n_da = 32'h8; n_wd = 32'hAABB_CCDD; n_be = 4'b0011;
        step();
        n_dw = 0;
        step();
        n_dw = 1; n_be = 4'b0000; n_wd = 32'h1111_1111;
        step();
        n_dw = 0;
        step();

        n_da = 32'h0008_0000; step();
        n_da = 32'h0000_0002; step();
        idle_in(); step();

        n_ir = 1; n_dr = 1; n_ia = 32'h4; n_da = 32'hC; n_pm = 1;
        repeat (10) step();
        n_pm = 0;
        repeat (3) step();
        n_pm = 1; n_dr = 0; step();
        n_pm = 0; idle_in(); step();

        n_ir = 1; n_ia = 32'h10;
        step();
        @(posedge clk);
        #2;
        rst = 1;
        q.delete();
        m_last = 1'b1;
        hold_if = '0;
        hold_d = '0;
        #1;
        chk("midrst_if_gnt", bus.if_gnt_o, 0);
        chk("midrst_d_gnt", bus.d_gnt_o, 0);
        chk("midrst_if_rvalid", bus.if_rvalid_o, 0);
        chk("midrst_if_rdata", bus.if_rdata_o, 0);
        chk("midrst_rd_en", bus.ram_rd_en_o, 0);
        chk("midrst_strb", bus.ram_wr_strb_o, 0);
        n_rst = 1; step();
        n_rst = 0; n_dr = 1; n_da = 32'h18;
        repeat (3) step();

        for (int k = 0; k < 600; k++) begin
            n_ir = ($urandom_range(0, 3) != 0);
            n_dr = ($urandom_range(0, 3) != 0);
            n_dw = $urandom_range(0, 1);
            n_ia = rnd_addr();
            n_da = rnd_addr();
            n_wd = $urandom;
            n_be = 4'($urandom_range(0, 15));
            n_pm = ($urandom_range(0, 7) == 0);
            n_rst = ($urandom_range(0, 99) == 0);
            step();
        end
        n_rst = 0;
        idle_in();
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter NB_COL, default 4, meaning byte columns per RAM word.
REQ-002 SHALL have parameter COL_WIDTH, default 8, meaning bits per column.
REQ-003 SHALL have parameter ADDR_W, default 17, meaning RAM word-address width (131072 words).
REQ-004 SHALL have these ports (DW = NB_COL*COL_WIDTH):
  clk_i  in  1  sole clock
  rst_i  in  1  asynchronous, active-high reset
  prog_mode_i  in  1  RAM UART programmer active; blocks all grants
  if_req_i  in  1  instruction-fetch read request
  if_addr_i  in  32  fetch byte address
  if_gnt_o  out  1  fetch request accepted this cycle
  if_rvalid_o  out  1  fetch response valid
  if_rdata_o  out  DW  fetch read data
  if_err_o  out  1  fetch response is an error
  d_req_i  in  1  data request
  d_we_i  in  1  1 = write, 0 = read
  d_addr_i  in  32  data byte address
  d_wdata_i  in  DW  write data
  d_be_i  in  NB_COL  byte enables
  d_gnt_o  out  1  data request accepted this cycle
  d_rvalid_o  out  1  data response valid (read data or write ack)
  d_rdata_o  out  DW  data read data
  d_err_o  out  1  data response is an error
  ram_rd_en_o  out  1  RAM read enable
  ram_rd_addr_o  out  ADDR_W  RAM read word address
  ram_wr_addr_o  out  ADDR_W  RAM write word address
  ram_wr_data_o  out  DW  RAM write data
  ram_wr_strb_o  out  NB_COL  RAM byte write strobes
  ram_rd_data_i  in  DW  RAM read data, valid 1 cycle after ram_rd_en_o

Function
REQ-005 SHALL grant at most one requester per cycle; gnt is combinational from req, prog_mode_i and arbiter state.
REQ-006 SHALL, with only one requester active, grant it in the same cycle (zero-wait).
REQ-007 SHALL, with both active, grant round-robin: the requester not granted last wins; pointer last_gnt (0 = IF, 1 = D) resets to 1 so IF wins the first tie.
REQ-008 SHALL update last_gnt only on a cycle with a grant.
REQ-009 SHALL hold both gnt low while prog_mode_i = 1, drive ram_wr_strb_o = 0 and ram_rd_en_o = 0, and suppress responses for requests presented in those cycles.
REQ-010 SHALL form word address = addr[ADDR_W+1:2]; a request is out of range when addr[31:ADDR_W+2] != 0 or addr[1:0] != 0.
REQ-011 SHALL, on a granted in-range read, assert ram_rd_en_o with ram_rd_addr_o in the grant cycle, and assert rvalid with rdata = ram_rd_data_i exactly 1 cycle later.
REQ-012 SHALL, on a granted in-range write, drive ram_wr_strb_o = d_be_i, ram_wr_addr_o and ram_wr_data_o in the grant cycle, and assert d_rvalid_o (rdata = 0, err = 0) 1 cycle later.
REQ-013 SHALL, on a granted out-of-range request, issue no RAM access and return rvalid with err = 1 and rdata = 0 one cycle later.
REQ-014 SHALL track responses with a 1-deep pipeline register {valid, owner, err}; grants may be issued back-to-back every cycle, one response per cycle, in grant order.
REQ-015 SHALL treat d_be_i = 0 with d_we_i = 1 as a granted write with no byte written and a normal ack.
REQ-016 SHALL keep ram_wr_strb_o = 0 on any cycle without a granted in-range data write; IF never writes.
REQ-017 SHALL hold rdata outputs stable (last value) while rvalid is low; err is low whenever rvalid is low.
REQ-018 SHALL, when prog_mode_i rises while a response is pending, still deliver that response on the next cycle.

Reset
REQ-019 SHALL, on rst_i = 1 (asynchronous), clear the response register, set last_gnt = 1, and drive all gnt, rvalid, err, ram_rd_en_o and ram_wr_strb_o to 0 and rdata to 0; a response pending at reset is discarded.
REQ-020 SHALL issue no grant during any cycle in which rst_i is asserted.

Verification
REQ-021 SHALL pass: IF-only read of 0x0000_0010 with RAM word 4 = 0x0000_0013 -> if_gnt_o same cycle, ram_rd_addr_o = 4, next cycle if_rvalid_o = 1, if_rdata_o = 0x0000_0013.
REQ-022 SHALL pass: IF and D both requesting continuously for 4 cycles after reset -> grant sequence IF, D, IF, D; 4 responses in the same order, one per cycle.
REQ-023 SHALL pass: D write 0xAABBCCDD to 0x0000_0008 with be = 4'b0011 -> ram_wr_strb_o = 4'b0011, ram_wr_addr_o = 2; next cycle d_rvalid_o = 1, d_err_o = 0.
REQ-024 SHALL pass: D read at 0x0008_0000 and at 0x0000_0002 -> no ram_rd_en_o; d_rvalid_o = 1, d_err_o = 1, d_rdata_o = 0 each.
REQ-025 SHALL pass: prog_mode_i = 1 for 10 cycles with both requesting -> no gnt, no RAM strobes; grants resume the cycle after prog_mode_i falls.
REQ-026 SHALL pass: rst_i pulsed mid-cycle the cycle after a granted read -> all outputs 0 immediately, no rvalid afterwards, and IF wins the first tie after release.
